serial_tx_arbiter: RTL and testbench

//   Round-robin scheduler sharing one bit-serial output pin between NUM_REQ message sources (e.g. ciphertext, key echo).

---
 rtl/serial_tx_arbiter_pkg.sv | 24 ++
 rtl/serial_tx_arbiter_rr_grant.sv | 39 +++
 rtl/serial_tx_arbiter.sv | 171 +++++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_arbiter_pkg.sv
// Shared definitions for the serial transmit arbiter: FSM state encoding and
// width helpers used by the top level and the round-robin grant block.
package serial_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Source index width; a single source still gets a 1-bit id.
  function automatic int unsigned src_w(input int unsigned num_req);
    return (num_req > 1) ? int'($clog2(num_req)) : 1;
  endfunction

  // One counter serves both the bit count (1..MSG_SIZE) and the gap count.
  function automatic int unsigned cnt_w(input int unsigned msg_size,
                                        input int unsigned gap_cycles);
    int unsigned top;
    top = (msg_size > gap_cycles) ? msg_size : gap_cycles;
    return int'($clog2(top + 1));
  endfunction

endpackage

// File: rtl/serial_tx_arbiter_rr_grant.sv
// Combinational round-robin grant: picks the first requesting index at or
// after the pointer, wrapping around.
//   req_i     request vector
//   ptr_i     round-robin start index
//   gnt_c_o   one-hot grant
//   idx_c_o   granted index
//   vld_c_o   at least one request present
module serial_tx_arbiter_rr_grant
  import serial_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned SRC_W   = src_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SRC_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_c_o,
  output logic [SRC_W-1:0]   idx_c_o,
  output logic               vld_c_o
);

  logic [SRC_W-1:0] cand_c;

  // Scan from the pointer; the first hit wins.
  always_comb begin
    gnt_c_o = '0;
    idx_c_o = '0;
    vld_c_o = 1'b0;
    cand_c  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_c = SRC_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!vld_c_o && req_i[cand_c]) begin
        vld_c_o         = 1'b1;
        gnt_c_o[cand_c] = 1'b1;
        idx_c_o         = cand_c;
      end
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin scheduler sharing one bit-serial pin between NUM_REQ sources.
// Grants a source, captures its word, shifts it out MSB first with a framing
// flag, then holds the flag low for GAP_CYCLES (plus one IDLE cycle).
//   clk, rst_n   clock, async active-low reset
//   ena          global enable; low freezes all state and quiets the pin
//   iReq         level request per source
//   iData_in     source k word at [k*MSG_SIZE +: MSG_SIZE]
//   oAck         1-cycle pulse: source word captured
//   oDone        1-cycle pulse: last bit of the source's frame on the pin
//   oData_out    serial data
//   oData_flag   high while oData_out carries a valid bit
//   oSrc_id      index of the source being sent (held between frames)
//   oBusy        high in SHIFT or GAP
module serial_tx_arbiter
  import serial_tx_arbiter_pkg::*;
#(
  parameter int unsigned MSG_SIZE   = 64,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic [NUM_REQ-1:0]           iReq,
  input  logic [NUM_REQ*MSG_SIZE-1:0]  iData_in,
  output logic [NUM_REQ-1:0]           oAck,
  output logic [NUM_REQ-1:0]           oDone,
  output logic                         oData_out,
  output logic                         oData_flag,
  output logic [src_w(NUM_REQ)-1:0]    oSrc_id,
  output logic                         oBusy
);

  localparam int unsigned SRC_W = src_w(NUM_REQ);
  localparam int unsigned CNT_W = cnt_w(MSG_SIZE, GAP_CYCLES);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [MSG_SIZE-1:0]   sr_q, sr_d;
  logic [SRC_W-1:0]      ptr_q, ptr_d;
  logic [SRC_W-1:0]      src_q, src_d;
  logic                  data_q, data_d;
  logic                  flag_q, flag_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic                  busy_q;

  logic [NUM_REQ-1:0]    gnt_c;
  logic [SRC_W-1:0]      idx_c;
  logic                  vld_c;
  logic [MSG_SIZE-1:0]   word_c;
  logic                  last_bit_c;
  logic                  gap_end_c;

  serial_tx_arbiter_rr_grant #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_rr_grant (
    .req_i   (iReq),
    .ptr_i   (ptr_q),
    .gnt_c_o (gnt_c),
    .idx_c_o (idx_c),
    .vld_c_o (vld_c)
  );

  // Word of the granted source.
  always_comb begin
    word_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (idx_c == SRC_W'(k)) word_c = iData_in[k*MSG_SIZE +: MSG_SIZE];
    end
  end

  // In SHIFT the counter equals the number of bits already put on the pin.
  assign last_bit_c = (cnt_q == CNT_W'(MSG_SIZE));
  assign gap_end_c  = (cnt_q == CNT_W'(GAP_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; ena low freezes the FSM.
  always_comb begin
    state_d = state_q;
    if (ena) begin
      unique case (state_q)
        ST_IDLE:  if (vld_c) state_d = ST_SHIFT;
        ST_SHIFT: if (last_bit_c) state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        ST_GAP:   if (gap_end_c) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and output next values; pin outputs default to quiet.
  always_comb begin
    cnt_d  = cnt_q;
    sr_d   = sr_q;
    ptr_d  = ptr_q;
    src_d  = src_q;
    data_d = 1'b0;
    flag_d = 1'b0;
    ack_d  = '0;
    done_d = '0;
    if (ena) begin
      unique case (state_q)
        ST_IDLE: begin
          if (vld_c) begin
            sr_d   = {word_c[MSG_SIZE-2:0], 1'b0};
            data_d = word_c[MSG_SIZE-1];
            flag_d = 1'b1;
            ack_d  = gnt_c;
            src_d  = idx_c;
            ptr_d  = (idx_c == SRC_W'(NUM_REQ - 1)) ? '0 : SRC_W'(idx_c + SRC_W'(1));
            cnt_d  = CNT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (!last_bit_c) begin
            data_d = sr_q[MSG_SIZE-1];
            sr_d   = {sr_q[MSG_SIZE-2:0], 1'b0};
            flag_d = 1'b1;
            cnt_d  = CNT_W'(cnt_q + CNT_W'(1));
            if (cnt_q == CNT_W'(MSG_SIZE - 1)) done_d = NUM_REQ'(1) << src_q;
          end else begin
            cnt_d = '0;
          end
        end
        ST_GAP: begin
          cnt_d = gap_end_c ? '0 : CNT_W'(cnt_q + CNT_W'(1));
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sr_q   <= '0;
      ptr_q  <= '0;
      src_q  <= '0;
      data_q <= 1'b0;
      flag_q <= 1'b0;
      ack_q  <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sr_q   <= sr_d;
      ptr_q  <= ptr_d;
      src_q  <= src_d;
      data_q <= data_d;
      flag_q <= flag_d;
      ack_q  <= ack_d;
      done_q <= done_d;
      busy_q <= (state_d != ST_IDLE);
    end
  end

  assign oAck       = ack_q;
  assign oDone      = done_q;
  assign oData_out  = data_q;
  assign oData_flag = flag_q;
  assign oSrc_id    = src_q;
  assign oBusy      = busy_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: directed scenarios followed by random traffic,
// with a transaction-level reference model feeding a scoreboard queue.
module tb_serial_tx_arbiter;

  localparam int MS = 64;
  localparam int NR = 2;
  localparam int GC = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ena;
  logic [NR-1:0]   iReq;
  logic [NR*MS-1:0] iData_in;
  logic [NR-1:0]   oAck;
  logic [NR-1:0]   oDone;
  logic            oData_out;
  logic            oData_flag;
  logic [0:0]      oSrc_id;
  logic            oBusy;

  serial_tx_arbiter #(
    .MSG_SIZE   (MS),
    .NUM_REQ    (NR),
    .GAP_CYCLES (GC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .iReq       (iReq),
    .iData_in   (iData_in),
    .oAck       (oAck),
    .oDone      (oDone),
    .oData_out  (oData_out),
    .oData_flag (oData_flag),
    .oSrc_id    (oSrc_id),
    .oBusy      (oBusy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int          src;
    logic [MS-1:0] word;
    int          ack_cyc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a source is granted at the first enabled cycle with the
  // pin free; a frame then occupies MS+GC enabled cycles before the next grant.
  int m_ptr  = 0;
  int m_busy = 0;
  int m_g;
  int m_i;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ptr  = 0;
      m_busy = 0;
      exp_q.delete();
    end else if (ena) begin
      if (m_busy > 0) begin
        m_busy--;
      end else if (iReq != '0) begin
        m_g = -1;
        for (int k = 0; k < NR; k++) begin
          m_i = (m_ptr + k) % NR;
          if (m_g < 0 && iReq[m_i]) m_g = m_i;
        end
        exp_q.push_back('{src: m_g, word: iData_in[m_g*MS +: MS], ack_cyc: cyc + 1});
        m_ptr  = (m_g + 1) % NR;
        m_busy = MS + GC;
      end
    end
  end

  // Monitor / scoreboard.
  bit          in_frame = 1'b0;
  exp_t        cur;
  exp_t        e;
  logic [MS-1:0] bits;
  int          nbits = 0;
  logic        ena_prev = 1'b1;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", 64'({oAck, oDone, oData_out, oData_flag, oSrc_id, oBusy}), 64'd0);
      in_frame = 1'b0;
      ena_prev = 1'b1;
    end else begin
      if (!ena_prev) chk("pause_quiet", 64'({oData_flag, oData_out}), 64'd0);
      if (oAck != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 64'(oAck), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_cycle", 64'(cyc), 64'(e.ack_cyc));
          chk("ack_vec", 64'(oAck), 64'd1 << e.src);
          chk("ack_src_id", 64'(oSrc_id), 64'(e.src));
          chk("ack_mid_frame", 64'(in_frame), 64'd0);
          in_frame = 1'b1;
          cur      = e;
          nbits    = 0;
          bits     = '0;
        end
      end else if (exp_q.size() > 0 && exp_q[0].ack_cyc < cyc) begin
        e = exp_q.pop_front();
        chk("missing_ack", 64'(oAck), 64'd1 << e.src);
      end
      if (oData_flag) begin
        if (!in_frame) begin
          chk("flag_outside_frame", 64'(oData_flag), 64'd0);
        end else begin
          bits  = {bits[MS-2:0], oData_out};
          nbits++;
          chk("frame_src_id", 64'(oSrc_id), 64'(cur.src));
          chk("frame_busy", 64'(oBusy), 64'd1);
        end
      end else begin
        chk("data_low_no_flag", 64'(oData_out), 64'd0);
      end
      if (oDone != '0) begin
        if (!in_frame) begin
          chk("done_outside_frame", 64'(oDone), 64'd0);
        end else begin
          chk("done_vec", 64'(oDone), 64'd1 << cur.src);
          chk("done_bit_count", 64'(nbits), 64'(MS));
          chk("done_with_flag", 64'(oData_flag), 64'd1);
          chk("frame_word", 64'(bits), 64'(cur.word));
          in_frame = 1'b0;
        end
      end else if (in_frame && nbits >= MS) begin
        chk("missing_done", 64'(oDone), 64'd1 << cur.src);
        in_frame = 1'b0;
      end
      ena_prev = ena;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int k);
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (oAck[k]) return;
    end
    chk("ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_any_ack(output int k);
    k = -1;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (oAck != '0) begin
        k = oAck[1] ? 1 : 0;
        return;
      end
    end
    chk("any_ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic set_word(input int k, input logic [MS-1:0] w);
    iData_in[k*MS +: MS] = w;
  endtask

  function automatic logic [MS-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  int a0;
  int a1;
  int kk;

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b1;
    iReq     = '0;
    iData_in = '0;
    step(3);
    rst_n = 1'b1;

    // Single frame from source 0 with a known pattern.
    while (cyc < 10) step(1);
    set_word(0, 64'hA5A5_0000_FFFF_1234);
    iReq = 2'b01;
    wait_ack(0);
    chk("t1_ack_cycle", 64'(cyc), 64'd11);
    iReq[0] = 1'b0;
    set_word(0, rnd_word());
    step(80);

    // Simultaneous requests after reset: src0 then src1, back to back.
    do_reset();
    set_word(0, rnd_word());
    set_word(1, rnd_word());
    iReq = 2'b11;
    wait_ack(0);
    a0 = cyc;
    iReq[0] = 1'b0;
    set_word(0, rnd_word());
    wait_ack(1);
    a1 = cyc;
    iReq[1] = 1'b0;
    set_word(1, rnd_word());
    chk("t2_ack_spacing", 64'(a1 - a0), 64'(MS + GC + 1));
    step(80);

    // src0 holds its request; src1 asks once and must still be served.
    iReq = 2'b11;
    wait_ack(0);
    wait_ack(1);
    iReq[1] = 1'b0;
    wait_ack(0);
    wait_ack(0);

    // Pause for 5 cycles in the middle of a frame.
    wait_ack(0);
    step(20);
    ena = 1'b0;
    step(5);
    ena = 1'b1;
    iReq[0] = 1'b0;
    step(80);

    // Asynchronous reset in mid-frame, requests pending.
    set_word(0, rnd_word());
    set_word(1, rnd_word());
    iReq = 2'b11;
    wait_any_ack(kk);
    step(30);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_reset", 64'({oAck, oDone, oData_out, oData_flag, oBusy}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ack(0);
    iReq[0] = 1'b0;
    wait_ack(1);
    iReq[1] = 1'b0;
    step(80);

    // Data changed right after ack; the other source withdraws before grant.
    set_word(0, rnd_word());
    set_word(1, rnd_word());
    iReq = 2'b11;
    wait_any_ack(kk);
    if (kk >= 0) begin
      set_word(kk, rnd_word());
      iReq[kk] = 1'b0;
    end
    step(10);
    iReq = '0;
    step(80);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      step(1);
      for (int k = 0; k < NR; k++) begin
        if (oAck[k]) begin
          if ($urandom_range(0, 1) == 0) iReq[k] = 1'b0;
          set_word(k, rnd_word());
        end else if (!iReq[k]) begin
          if ($urandom_range(0, 19) == 0) begin
            set_word(k, rnd_word());
            iReq[k] = 1'b1;
          end
        end else if ($urandom_range(0, 299) == 0) begin
          iReq[k] = 1'b0;
        end
      end
      ena = ($urandom_range(0, 29) != 0);
    end

    // Drain.
    ena  = 1'b1;
    iReq = '0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !in_frame) break;
      step(1);
    end
    step(5);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("no_open_frame", 64'(in_frame), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
